// File: rtl/c1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : c1_pkg
//  Description : Shared C1 bus definitions: command codes, port FSM state
//                type and a command-acceptance helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package c1_pkg;

    // C1 command codes; code 7 doubles as WRITE32 (CPU) and RESPONSE (cache)
    localparam logic [2:0] C1_NOP          = 3'd0;
    localparam logic [2:0] C1_READ8        = 3'd1;
    localparam logic [2:0] C1_READ16       = 3'd2;
    localparam logic [2:0] C1_READ32       = 3'd3;
    localparam logic [2:0] C1_INV_LINE     = 3'd4;
    localparam logic [2:0] C1_WRITE8       = 3'd5;
    localparam logic [2:0] C1_WRITE16      = 3'd6;
    localparam logic [2:0] C1_WRITE32_RESP = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_A2    = 3'd1,
        ST_TURN  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_RESP1 = 3'd5,
        ST_RESP2 = 3'd6
    } c1_state_t;

    // A command starts a transaction only for codes 1..6; an unknown or
    // floating bus reads as NOP, and code 7 is the cache's own response code.
    function automatic logic c1_is_request(input logic [2:0] cmd);
        return (^cmd !== 1'bx) && (cmd != C1_NOP) && (cmd != C1_WRITE32_RESP);
    endfunction

endpackage : c1_pkg
`default_nettype wire

// File: rtl/cache_c1_port.sv
`default_nettype none
// ============================================================================
//  Module      : cache_c1_port
//  Description : C1 bus front end of the cache. Captures the two-cycle
//                command/address/data phase, issues one request to the cache
//                core and returns the C1 response, driving the shared
//                tri-state c1_cmd/c1_data lines only while it owns them.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_c1_port
    import c1_pkg::*;
#(
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int BUS_SIZE          = 16,
    parameter int CACHE_OFFSET_SIZE = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] c1_addr,
    inout  wire  [BUS_SIZE-1:0]                    c1_data,
    inout  wire  [2:0]                             c1_cmd,
    output logic                                   core_req_valid,
    input  logic                                   core_req_ready,
    output logic [2:0]                             core_req_op,
    output logic [MEM_ADDR_SIZE-1:0]               core_req_addr,
    output logic [2*BUS_SIZE-1:0]                  core_req_wdata,
    input  logic                                   core_resp_valid,
    input  logic [2*BUS_SIZE-1:0]                  core_resp_rdata
);

    localparam int c_tagset_size = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;

    c1_state_t                     r_state;
    logic [2:0]                    r_op;
    logic [c_tagset_size-1:0]      r_tagset;
    logic [CACHE_OFFSET_SIZE-1:0]  r_offset;
    logic [BUS_SIZE-1:0]           r_word0;
    logic [BUS_SIZE-1:0]           r_word1;
    logic [BUS_SIZE-1:0]           r_rdata_hi;
    logic                          r_cmd_oe;
    logic [2:0]                    r_cmd_out;
    logic                          r_data_oe;
    logic [BUS_SIZE-1:0]           r_data_out;

    logic [2*BUS_SIZE-1:0]         w_wdata;
    logic [BUS_SIZE-1:0]           w_resp_lo;
    logic                          w_is_read;

    // The bus lines are only driven while the output-enable registers say so
    assign c1_cmd  = r_cmd_oe  ? r_cmd_out  : 'z;
    assign c1_data = r_data_oe ? r_data_out : 'z;

    assign w_is_read = (r_op == C1_READ8) || (r_op == C1_READ16) || (r_op == C1_READ32);

    // Write payload sized by the op; bytes the op does not carry are zero
    always_comb begin
        w_wdata = '0;
        case (r_op)
            C1_WRITE8:       w_wdata[7:0]          = r_word0[7:0];
            C1_WRITE16:      w_wdata[BUS_SIZE-1:0] = r_word0;
            C1_WRITE32_RESP: w_wdata               = {r_word1, r_word0};
            default:         w_wdata               = '0;
        endcase
    end

    // First response beat: READ8 returns only the low byte, zero-extended
    always_comb begin
        w_resp_lo = core_resp_rdata[BUS_SIZE-1:0];
        if (r_op == C1_READ8) begin
            w_resp_lo      = '0;
            w_resp_lo[7:0] = core_resp_rdata[7:0];
        end
    end

    // Port FSM: capture, turnaround, core handshake and response beats
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_op           <= C1_NOP;
            r_tagset       <= '0;
            r_offset       <= '0;
            r_word0        <= '0;
            r_word1        <= '0;
            r_rdata_hi     <= '0;
            r_cmd_oe       <= 1'b0;
            r_cmd_out      <= C1_NOP;
            r_data_oe      <= 1'b0;
            r_data_out     <= '0;
            core_req_valid <= 1'b0;
            core_req_op    <= C1_NOP;
            core_req_addr  <= '0;
            core_req_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (c1_is_request(c1_cmd)) begin
                        r_op     <= c1_cmd;
                        r_tagset <= c1_addr;
                        r_word0  <= c1_data;
                        r_state  <= ST_A2;
                    end
                end
                ST_A2: begin
                    r_offset <= c1_addr[CACHE_OFFSET_SIZE-1:0];
                    r_word1  <= c1_data;
                    r_state  <= ST_TURN;
                end
                ST_TURN: begin
                    // CPU has released c1_cmd; take it over and present the request
                    r_cmd_oe       <= 1'b1;
                    r_cmd_out      <= C1_NOP;
                    core_req_valid <= 1'b1;
                    core_req_op    <= r_op;
                    core_req_addr  <= {r_tagset, r_offset};
                    core_req_wdata <= w_wdata;
                    r_state        <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (core_req_ready) begin
                        core_req_valid <= 1'b0;
                        r_state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (core_resp_valid) begin
                        r_rdata_hi <= core_resp_rdata[2*BUS_SIZE-1:BUS_SIZE];
                        r_cmd_out  <= C1_WRITE32_RESP;
                        // For writes/INV_LINE the CPU still owns c1_data
                        r_data_oe  <= w_is_read;
                        r_data_out <= w_resp_lo;
                        r_state    <= ST_RESP1;
                    end
                end
                ST_RESP1: begin
                    if (r_op == C1_READ32) begin
                        r_data_out <= r_rdata_hi;
                        r_state    <= ST_RESP2;
                    end else begin
                        r_cmd_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_RESP2: begin
                    r_cmd_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_cmd_oe       <= 1'b0;
                    r_data_oe      <= 1'b0;
                    core_req_valid <= 1'b0;
                    r_state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : cache_c1_port
`default_nettype wire

// File: tb/tb_cache_c1_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_c1_port
//  Description : Self-checking bench for cache_c1_port. Plays the CPU and the
//                cache core, and compares the port's behaviour against a
//                transaction-level model of the C1 protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_c1_port;

    localparam int MEM_ADDR_SIZE     = 19;
    localparam int BUS_SIZE          = 16;
    localparam int CACHE_OFFSET_SIZE = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] c1_addr;
    wire  [15:0] c1_data;
    wire  [2:0]  c1_cmd;
    logic        core_req_valid;
    logic        core_req_ready;
    logic [2:0]  core_req_op;
    logic [18:0] core_req_addr;
    logic [31:0] core_req_wdata;
    logic        core_resp_valid;
    logic [31:0] core_resp_rdata;

    // CPU-side drivers of the shared lines
    logic        cpu_cmd_oe;
    logic [2:0]  cpu_cmd;
    logic        cpu_data_oe;
    logic [15:0] cpu_data;

    assign c1_cmd  = cpu_cmd_oe  ? cpu_cmd  : 3'bz;
    assign c1_data = cpu_data_oe ? cpu_data : 16'bz;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    cache_c1_port #(
        .MEM_ADDR_SIZE    (MEM_ADDR_SIZE),
        .BUS_SIZE         (BUS_SIZE),
        .CACHE_OFFSET_SIZE(CACHE_OFFSET_SIZE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .c1_addr        (c1_addr),
        .c1_data        (c1_data),
        .c1_cmd         (c1_cmd),
        .core_req_valid (core_req_valid),
        .core_req_ready (core_req_ready),
        .core_req_op    (core_req_op),
        .core_req_addr  (core_req_addr),
        .core_req_wdata (core_req_wdata),
        .core_resp_valid(core_resp_valid),
        .core_resp_rdata(core_resp_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive zero on both lines ourselves: any value the port drives shows up
    // as a difference (or contention) on the resolved net.
    task automatic check_released(input string tag);
        cpu_cmd_oe  = 1'b1; cpu_cmd  = 3'd0;
        cpu_data_oe = 1'b1; cpu_data = 16'h0;
        #1;
        check_eq({tag, "_cmd"},  32'(c1_cmd),  32'd0);
        check_eq({tag, "_data"}, 32'(c1_data), 32'd0);
        cpu_cmd_oe  = 1'b0;
        cpu_data_oe = 1'b0;
    endtask

    task automatic apply_reset_cycle(input string tag);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq({tag, "_valid"}, 32'(core_req_valid), 32'd0);
        check_eq({tag, "_op"},    32'(core_req_op),    32'd0);
        check_eq({tag, "_addr"},  32'(core_req_addr),  32'd0);
        check_eq({tag, "_wdata"}, core_req_wdata,      32'd0);
        check_released(tag);
    endtask

    // One CPU transaction. Called at a negedge with the bus idle.
    // rmode: 0 normal, 1 reset while waiting for the core, 2 reset in first response beat
    task automatic run_txn(input logic [2:0] op, input logic [14:0] ts, input logic [3:0] off,
                           input logic [15:0] w0, input logic [15:0] w1, input logic [31:0] rd,
                           input int stall, input int delay, input int rmode);
        logic        accepted, is_read;
        logic [18:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [15:0] exp_beat[$];
        int          t0;

        // Transaction-level expectations
        accepted  = (op >= 3'd1) && (op <= 3'd6);
        is_read   = (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
        exp_addr  = {ts, off};
        exp_wdata = 32'h0;
        if (op == 3'd5) exp_wdata = {24'h0, w0[7:0]};
        if (op == 3'd6) exp_wdata = {16'h0, w0};
        exp_beat.delete();
        if (op == 3'd1) exp_beat.push_back({8'h0, rd[7:0]});
        if (op == 3'd2 || op == 3'd3) exp_beat.push_back(rd[15:0]);
        if (op == 3'd3) exp_beat.push_back(rd[31:16]);

        // A1: command, tag+set, word0
        cpu_cmd_oe = 1'b1; cpu_cmd = op; c1_addr = ts;
        cpu_data_oe = 1'b1; cpu_data = w0;
        @(posedge clk); #1;
        t0 = cyc;
        // A2: offset, word1
        c1_addr  = {11'($urandom), off};
        cpu_data = w1;

        if (!accepted) begin
            cpu_cmd_oe = 1'b0; cpu_data_oe = 1'b0;
            repeat (4) begin
                @(negedge clk);
                check_eq("ignored_valid", 32'(core_req_valid), 32'd0);
                check_released("ignored_bus");
            end
            return;
        end

        @(posedge clk); #1;
        cpu_cmd_oe = 1'b0;
        if (is_read) cpu_data_oe = 1'b0;
        else         cpu_data    = 16'h0;
        @(negedge clk);
        check_eq("turn_valid", 32'(core_req_valid), 32'd0);

        // Request phase with optional core stall and stray response pulses
        for (int i = 0; i <= stall; i++) begin
            @(negedge clk);
            check_eq("req_valid", 32'(core_req_valid), 32'd1);
            check_eq("req_op",    32'(core_req_op),    32'(op));
            check_eq("req_addr",  32'(core_req_addr),  32'(exp_addr));
            check_eq("req_wdata", core_req_wdata,      exp_wdata);
            check_eq("req_cmd_nop", 32'(c1_cmd),       32'd0);
            core_req_ready  = (i == stall);
            core_resp_valid = (i != stall) && ($urandom_range(0, 2) == 0);
            core_resp_rdata = $urandom;
        end
        @(negedge clk);
        core_req_ready  = 1'b0;
        core_resp_valid = 1'b0;
        check_eq("req_drop",  32'(core_req_valid), 32'd0);
        check_eq("wait_cmd",  32'(c1_cmd),         32'd0);

        if (rmode == 1) begin
            apply_reset_cycle("rst_wait");
            core_resp_valid = 1'b1; core_resp_rdata = rd;
            @(negedge clk);
            core_resp_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                check_eq("late_resp_valid", 32'(core_req_valid), 32'd0);
                check_released("late_resp_bus");
                @(negedge clk);
            end
            return;
        end

        for (int i = 0; i <= delay; i++) begin
            if (i > 0) begin
                @(negedge clk);
                check_eq("wait_cmd", 32'(c1_cmd), 32'd0);
            end
            core_resp_valid = (i == delay);
            core_resp_rdata = (i == delay) ? rd : $urandom;
        end
        @(negedge clk);
        core_resp_valid = 1'b0;
        core_resp_rdata = $urandom;

        // First response beat
        check_eq("latency_edges", 32'(cyc - t0), 32'(4 + stall + delay));
        check_eq("resp1_cmd", 32'(c1_cmd), 32'd7);
        if (is_read) check_eq("resp1_data", 32'(c1_data), 32'(exp_beat[0]));
        else         check_eq("wr_data_undriven", 32'(c1_data), 32'd0);

        if (rmode == 2) begin
            cpu_data_oe = 1'b0;
            apply_reset_cycle("rst_resp1");
            @(negedge clk);
            check_eq("after_rst_valid", 32'(core_req_valid), 32'd0);
            check_released("after_rst_bus");
            return;
        end

        if (exp_beat.size() == 2) begin
            @(negedge clk);
            check_eq("resp2_cmd",  32'(c1_cmd),  32'd7);
            check_eq("resp2_data", 32'(c1_data), 32'(exp_beat[1]));
        end

        @(negedge clk);
        cpu_data_oe = 1'b0;
        check_eq("post_valid", 32'(core_req_valid), 32'd0);
        check_released("post_resp");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        c1_addr         = '0;
        cpu_cmd_oe      = 1'b0; cpu_cmd  = 3'd0;
        cpu_data_oe     = 1'b0; cpu_data = 16'h0;
        core_req_ready  = 1'b0;
        core_resp_valid = 1'b0;
        core_resp_rdata = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(core_req_valid), 32'd0);
        check_eq("rst_op",    32'(core_req_op),    32'd0);
        check_eq("rst_addr",  32'(core_req_addr),  32'd0);
        check_eq("rst_wdata", core_req_wdata,      32'd0);
        check_released("rst_bus");
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        run_txn(3'd6, 15'd2, 4'd2, 16'h5555, 16'hAAAA, 32'h0,        0, 0, 0);
        run_txn(3'd3, 15'd2, 4'd0, 16'h1111, 16'h2222, 32'hDEAD5555, 0, 0, 0);
        run_txn(3'd1, 15'd2, 4'd2, 16'h3333, 16'h4444, 32'h12345678, 0, 0, 0);
        run_txn(3'd2, 15'h1234, 4'h9, 16'h0, 16'h0,    32'hCAFEBABE, 4, 1, 0);
        run_txn(3'd0, 15'h7FFF, 4'hF, 16'hFFFF, 16'hFFFF, 32'h0,     0, 0, 0);
        run_txn(3'd7, 15'h7FFF, 4'hF, 16'hFFFF, 16'hFFFF, 32'h0,     0, 0, 0);
        // Floating command line while idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("float_valid", 32'(core_req_valid), 32'd0);
            check_released("float_bus");
        end
        run_txn(3'd5, 15'h0ABC, 4'h3, 16'hBEEF, 16'h0, 32'h0,        1, 2, 0);
        run_txn(3'd2, 15'h0042, 4'h1, 16'h0, 16'h0,    32'h0BAD0BAD, 0, 2, 1);
        run_txn(3'd3, 15'h0043, 4'h2, 16'h0, 16'h0,    32'hFACEB00C, 1, 0, 2);
        run_txn(3'd2, 15'h0044, 4'h3, 16'h0, 16'h0,    32'h8765ABCD, 0, 0, 0);

        // Randomized traffic
        repeat (60) begin
            run_txn(3'($urandom_range(0, 7)), 15'($urandom), 4'($urandom),
                    16'($urandom), 16'($urandom), $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 3), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cache_c1_port
`default_nettype wire
